// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the multiplexed BCD 7-segment display scanner.
// Segment codes are high-true, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to high-true 7-segment decoder; codes A..F show a dash.
module bcd_to_7seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame digit snapshot,
// optional leading-zero blanking and registered, polarity-configurable outputs.
module bcd_display_scan
   import bcd_disp_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bcd_in,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_RST  = SEG_ACTIVE_LOW;
   localparam logic [3:0] AN_RST  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

   logic [PW-1:0]            pcnt_q, pcnt_d;
   digit_idx_t               idx_q, idx_d;
   logic [15:0]              snap_q, snap_d;
   logic [NUM_DIGITS-1:0]    snap_dp_q, snap_dp_d;
   logic                     primed_q, primed_d;
   logic [6:0]               seg_q, seg_d;
   logic                     dp_q, dp_d;
   logic [3:0]               an_q, an_d;
   logic                     frame_tick_q, frame_tick_d;

   logic       wrap, load, blank, dp_ht;
   logic [3:0] cur_nib, an_ht;
   logic [6:0] dec_seg, seg_ht;

   bcd_to_7seg u_dec (
      .bcd (cur_nib),
      .seg (dec_seg)
   );

   // The priming cycle holds the prescaler at 0 so the first frame is as long as every other.
   always_comb begin
      wrap         = (pcnt_q == PCNT_LAST);
      load         = !primed_q || (wrap && idx_q == 2'd3);
      pcnt_d       = (!primed_q || wrap) ? '0 : pcnt_q + 1'b1;
      idx_d        = (primed_q && wrap) ? idx_q + 2'd1 : idx_q;
      snap_d       = load ? bcd_in : snap_q;
      snap_dp_d    = load ? dp_in : snap_dp_q;
      primed_d     = 1'b1;
      frame_tick_d = load;

      cur_nib = snap_q[{idx_q, 2'b00} +: 4];
      case (idx_q)
         2'd3:    blank = BLANK_LZ && (snap_q[15:12] == 4'd0);
         2'd2:    blank = BLANK_LZ && (snap_q[15:8] == 8'd0);
         2'd1:    blank = BLANK_LZ && (snap_q[15:4] == 12'd0);
         default: blank = 1'b0;
      endcase

      seg_ht = blank ? SEG_OFF : dec_seg;
      dp_ht  = !blank && snap_dp_q[idx_q];
      an_ht  = blank ? 4'h0 : 4'(4'b0001 << idx_q);

      seg_d = SEG_ACTIVE_LOW ? ~seg_ht : seg_ht;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_ht : dp_ht;
      an_d  = AN_ACTIVE_LOW ? ~an_ht : an_ht;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pcnt_q       <= '0;
         idx_q        <= '0;
         snap_q       <= '0;
         snap_dp_q    <= '0;
         primed_q     <= 1'b0;
         seg_q        <= SEG_RST;
         dp_q         <= DP_RST;
         an_q         <= AN_RST;
         frame_tick_q <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         idx_q        <= idx_d;
         snap_q       <= snap_d;
         snap_dp_q    <= snap_dp_d;
         primed_q     <= primed_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: two instances (blanking on/off) share inputs;
// expected outputs are queued per edge from a frame-position model and checked after it.
module tb_bcd_display_scan;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] bcd_in = 16'h0000;
   logic [3:0]  dp_in = 4'h0;

   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;
   logic [3:0]  an_a, an_b;
   logic        tick_a, tick_b;

   int compared = 0;
   int mismatched = 0;
   int cycle = 0;

   typedef struct {
      logic [11:0] disp_a;
      logic [11:0] disp_b;
      logic        tick;
   } exp_t;

   exp_t sb[$];

   // Model state: snapshot held by the model and edges seen since reset release.
   logic [15:0] m_snap = 16'h0000;
   logic [3:0]  m_dp = 4'h0;
   int          m_n = 0;

   always #5 clk = ~clk;

   bcd_display_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .seg        (seg_a),
      .dp         (dp_a),
      .an         (an_a),
      .frame_tick (tick_a)
   );

   bcd_display_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .seg        (seg_b),
      .dp         (dp_b),
      .an         (an_b),
      .frame_tick (tick_b)
   );

   function automatic logic [6:0] segOf(input logic [3:0] nib);
      logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      if (nib > 4'd9) return 7'h40;
      return tbl[nib];
   endfunction

   // Active-low {an, seg, dp} for one digit slot of a given snapshot.
   function automatic logic [11:0] expDisplay(input logic [15:0] s, input logic [3:0] d,
                                              input int idx, input bit blz);
      logic [15:0] upper;
      logic [3:0]  nib;
      logic [3:0]  an_hot;
      upper  = s >> (idx * 4);
      nib    = upper[3:0];
      an_hot = 4'b0001 << idx;
      if (blz && idx > 0 && upper == 16'h0000) return {4'hF, 7'h7F, 1'b1};
      return {~an_hot, ~segOf(nib), ~d[idx]};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", tag, cycle, got, exp);
      end
   endtask

   // One clock per call step: drive, queue the expected result of the coming edge, check after it.
   task automatic applyStimulus(input logic r, input logic [15:0] bcd, input logic [3:0] dpv,
                                input int cycles);
      exp_t e, got;
      int   idx;
      bit   load;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         rst    = r;
         bcd_in = bcd;
         dp_in  = dpv;
         if (!r) begin
            e.disp_a = {4'hF, 7'h7F, 1'b1};
            e.disp_b = {4'hF, 7'h7F, 1'b1};
            e.tick   = 1'b0;
            m_snap   = 16'h0000;
            m_dp     = 4'h0;
            m_n      = 0;
         end else begin
            idx      = (m_n == 0) ? 0 : ((m_n - 1) / SD) % 4;
            e.disp_a = expDisplay(m_snap, m_dp, idx, 1'b1);
            e.disp_b = expDisplay(m_snap, m_dp, idx, 1'b0);
            load     = (m_n % (4 * SD)) == 0;
            e.tick   = load;
            if (load) begin
               m_snap = bcd;
               m_dp   = dpv;
            end
            m_n++;
         end
         sb.push_back(e);
         @(posedge clk);
         #1;
         cycle++;
         got = sb.pop_front();
         checkOutput("an_a",   {12'h0, an_a},  {12'h0, got.disp_a[11:8]});
         checkOutput("seg_a",  {9'h0, seg_a},  {9'h0, got.disp_a[7:1]});
         checkOutput("dp_a",   {15'h0, dp_a},  {15'h0, got.disp_a[0]});
         checkOutput("tick_a", {15'h0, tick_a}, {15'h0, got.tick});
         checkOutput("an_b",   {12'h0, an_b},  {12'h0, got.disp_b[11:8]});
         checkOutput("seg_b",  {9'h0, seg_b},  {9'h0, got.disp_b[7:1]});
         checkOutput("dp_b",   {15'h0, dp_b},  {15'h0, got.disp_b[0]});
         checkOutput("tick_b", {15'h0, tick_b}, {15'h0, got.tick});
      end
   endtask

   initial begin
      $display("[TB] start, SCAN_DIV=%0d", SD);

      applyStimulus(1'b0, 16'h0000, 4'h0, 3);
      applyStimulus(1'b1, 16'h9675, 4'h0, 40);

      applyStimulus(1'b1, 16'h0042, 4'h0, 36);
      applyStimulus(1'b1, 16'h0000, 4'h0, 32);

      // Frame coherency: new value appears mid-frame and must wait for the next load.
      applyStimulus(1'b1, 16'h1234, 4'h0, 20);
      applyStimulus(1'b1, 16'h5678, 4'h0, 32);

      applyStimulus(1'b1, 16'h00A0, 4'b0010, 36);
      applyStimulus(1'b1, 16'h0300, 4'b1001, 32);

      // Reset in the middle of a scan, then restart.
      applyStimulus(1'b1, 16'h9675, 4'h0, 10);
      applyStimulus(1'b0, 16'h9675, 4'h0, 2);
      applyStimulus(1'b1, 16'h4321, 4'h0, 24);

      for (int k = 0; k < 20; k++) begin
         logic [15:0] v;
         v = 16'($urandom);
         if (k % 3 == 0) v[15:8] = 8'h00;
         applyStimulus(1'b1, v, 4'($urandom), 7);
      end

      checkOutput("sb_empty", 16'(sb.size()), 16'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the cascaded BCD digit counters in the 0-to-9675 counter.
- Takes the four packed BCD digits (thousands..units) and drives a 4-digit time-multiplexed common-anode 7-segment display.
- Snapshots the digits once per scan frame so that a display frame never mixes two counter values.
- Optionally blanks leading zeros and renders non-BCD codes as '-'.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays lit; legal minimum 2.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp driven low-true; 0 = high-true.
- AN_ACTIVE_LOW, 1: 1 = anode enables low-true; 0 = high-true.
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show all four digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- bcd_in  in  16  packed digits; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- dp_in  in  4  decimal-point request per digit; bit i belongs to digit i (0 = units).
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point of the lit digit, polarity per SEG_ACTIVE_LOW.
- an  out  4  digit enables; bit i = digit i; polarity per AN_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse in the cycle the snapshot loads.

Behaviour:
- Reset (rst=0 at a rising edge):
  - pcnt=0, idx=0, snap=0, snap_dp=0, primed=0.
  - All an inactive, all seg/dp off, frame_tick=0.
- Prescaler pcnt:
  - Counts 0..SCAN_DIV-1 and wraps.
  - In the wrap cycle (pcnt==SCAN_DIV-1), idx advances 0→1→2→3→0.
- Snapshot load (snap<=bcd_in, snap_dp<=dp_in, frame_tick=1 for that cycle) occurs on either:
  - the first clock after reset release (primed=0; primed then set to 1), or
  - the cycle in which pcnt wraps with idx==3.
- No other cycle alters snap. bcd_in changes mid-frame have no visible effect until the next load.
- Output latency: seg/dp/an are registered from the current (idx, snap, snap_dp), so they reflect the state one cycle after it changes.
- Exactly one an is active per cycle, except when the selected digit is blanked; then no an is active and seg/dp are off.
- Decode (high-true, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A..F render as '-' = 40.
  - Outputs are inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=3..1) is blanked iff snap digits k..3 are all 0.
  - The units digit is never blanked.
  - A non-BCD nibble counts as non-zero.
  - The blanking condition takes precedence over dp_in for that digit.
- Reset mid-scan: takes effect on the next edge; outputs go to their reset values immediately. The scan restarts at idx 0 with a fresh snapshot one cycle after release.
- rst held low: outputs stay at their reset values; no frame_tick.

Decomposition:
- Package bcd_disp_pkg:
  - NUM_DIGITS=4.
  - Seven-segment code constants SEG_0..SEG_9 and SEG_DASH, SEG_OFF.
  - Digit-index type (2 bits).
- Sub-module bcd_to_7seg: combinational nibble→7-bit high-true decoder, including the dash for A..F.
- Polarity inversion, blanking and registering live in bcd_display_scan.

Test Plan:
- Reset: rst=0 for 3 cycles, SCAN_DIV=4, defaults → an=1111, seg=7F, dp=1, frame_tick=0. After release, frame_tick pulses on the first edge, then pulses every 16 cycles.
- Scan of 9675 (bcd_in=16'h9675, dp_in=0, SCAN_DIV=4) → runs of 4 cycles each, in this order:
  - an=1110, seg=12
  - an=1101, seg=78
  - an=1011, seg=02
  - an=0111, seg=10
  - then repeats.
- Leading zeros: bcd_in=16'h0042 → digits 3 and 2 have an=1111 during their slots; digit1 seg=19, digit0 seg=24. bcd_in=16'h0000 → only digit0 lit, seg=40. With BLANK_LZ=0 and bcd_in=16'h0042, all four digits lit; digits 3 and 2 show seg=40.
- Frame coherency: load 16'h1234, change bcd_in to 16'h5678 during the idx=1 slot → digits 1..3 of that frame still show 3,2,1. Next frame, after frame_tick, shows 8,7,6,5.
- Non-BCD and dp: bcd_in=16'h00A0, dp_in=4'b0010 → digit1 seg=3F (dash), dp=0. Digit0 seg=40, dp=1. Digits 3 and 2 blanked.
- Reset mid-scan: assert rst=0 during the idx=2 slot → outputs go to reset values on the next edge. After release, idx=0 and a new snapshot is taken; the first lit slot is an=1110.
